pattern_count_engine: RTL and testbench
=======================================

// Module: pattern_count_engine
// PURPOSE
//  Hardware accelerator for the program-3 pattern search. Scans 32 message bytes in
//  data memory against a 5-bit pattern and counts matches three ways. Writes the
//  three counts back to data memory and raises done. Sits beside the CPU as a second
//  master on the data-memory port; the program-3 bench reads its results.
// PARAMETERS
//  N_BYTES   32  message length in bytes, at addresses MSG_BASE..MSG_BASE+N_BYTES-1
//  MSG_BASE  0   address of the first message byte (MSB of the bit string)
//  PAT_ADDR  32  address holding the pattern in bits [7:3]; bits [2:0] are ignored
//  RES_ADDR  33  ctb at RES_ADDR, cto at RES_ADDR+1, cts at RES_ADDR+2
//  AW        8   memory address width
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low; reset=0 forces the reset state
//  start        in   1   one-cycle request; sampled only in IDLE
//  mem_addr     out  AW  memory address (read or write)
//  mem_rd_data  in   8   read data, valid the cycle after mem_addr is presented
//  mem_wr_en    out  1   write strobe for the current cycle
//  mem_wr_data  out  8   write data
//  busy         out  1   high from the start accept until done
//  done         out  1   level; held high in DONE until the next accepted start
// BEHAVIOUR
//  Reset values: mem_addr=0, mem_wr_en=0, mem_wr_data=0, busy=0, done=0.
//  Counters ctb, cto and cts and the 4-bit carry register are also cleared.
//  FSM: IDLE -> RD_PAT -> SCAN -> WR_CTB -> WR_CTO -> WR_CTS -> DONE.
//   IDLE:   start=1 clears all counters and enters RD_PAT.
//   RD_PAT: mem_addr=PAT_ADDR.
//   SCAN:   captures pat=rd[7:3], then issues N_BYTES sequential reads.
//           The 1-cycle read latency is pipelined, so one byte is consumed per cycle.
//   WR_*:   one cycle each, mem_wr_en=1 at RES_ADDR+0/+1/+2.
//   DONE:   done=1. start=1 re-runs the scan and clears done in the same edge.
//  Per consumed byte b (index i):
//   - w = number of k in 0..3 with b[k+4:k]==pat (0..4).
//   - ctb += w.
//   - cto += (w!=0).
//   - cts += w.
//   - For i>0, cts also adds crossing matches: windows {c[3:0],b}[k+4:k], k=4..7.
//     c is the previous byte's low nibble.
//   - c <= b[3:0] after every byte.
//   - Totals: 4+8*(N_BYTES-1) = 252 windows for N_BYTES=32; no window wraps past the last byte.
//  Width rules:
//   - All counters are 8-bit unsigned.
//   - Maxima: ctb=128, cto=32, cts=252, so no saturation logic is needed.
//  Latency: done rises exactly N_BYTES+6 cycles after the start-accept edge (38 by default).
//  Boundary conditions:
//   - start while busy is ignored.
//   - start held high in DONE starts exactly one new run.
//   - reset low mid-run returns to IDLE and suppresses any pending write.
//   - Memory is not restored after reset.
//   - pattern byte changed during SCAN has no effect; pat is latched once.
//   - All-identical bytes are handled like any other data.
// STRUCTURE
//  Package pce_pkg holds:
//   - typedef enum logic[2:0] pce_state_t for the FSM states;
//   - localparams PAT_W=5, WIN_PER_BYTE=4, CROSS_WIN=4.
//  Sub-module pce_window_match:
//   - combinational;
//   - inputs {c[3:0],b[7:0]} and pat;
//   - outputs in_byte count (3b) and cross count (3b).
//  Top holds the FSM, address counter, read pipeline valid bit, counters and write mux.
// TESTING (golden model = the three count loops of the program-3 bench)
//  1. All bytes 8'h00, pat=5'b00000 -> ctb=128, cto=32, cts=252. done at cycle 38.
//  2. All bytes 8'h55, pat=5'b10101 -> ctb=64, cto=32, cts=126.
//  3. All bytes 8'hF0, pat=5'b11111 -> ctb=0, cto=0, cts=0.
//     mem[33..35] are written with 0, not skipped.
//  4. 200 random strings plus random pat -> mem[33..35] match the model every run.
//     busy=1 and done=0 throughout each scan.
//  5. Reset mid-scan:
//     - pulse reset=0 at cycle 15 -> outputs at reset values; mem[33..35] untouched.
//     - next start gives correct counts.
//  6. start pulsed at cycles 5 and 20 of a run -> ignored; one set of writes.
//     start in DONE -> done drops and a second identical result set is written.

Source files
------------

// File: rtl/pce_pkg.sv
// Shared types and constants for the pattern count engine.
package pce_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdPat,
    StScan,
    StWrCtb,
    StWrCto,
    StWrCts,
    StDone
  } pce_state_t;

  localparam int unsigned PAT_W        = 5;
  localparam int unsigned WIN_PER_BYTE = 4;
  localparam int unsigned CROSS_WIN    = 4;

endpackage

// File: rtl/pce_window_match.sv
// Counts 5-bit pattern hits inside one byte and across the boundary with the
// previous byte's low nibble.
module pce_window_match
  import pce_pkg::*;
(
  input  logic [11:0]      win_bits,
  input  logic [PAT_W-1:0] pat,
  output logic [2:0]       in_byte_cnt,
  output logic [2:0]       cross_cnt
);

  // win_bits = {prev_low_nibble, byte}; windows 0..3 lie in the byte, 4..7 straddle.
  always_comb begin
    in_byte_cnt = 3'd0;
    cross_cnt   = 3'd0;
    for (int k = 0; k < WIN_PER_BYTE; k++) begin
      if (win_bits[k +: PAT_W] == pat) in_byte_cnt = in_byte_cnt + 3'd1;
    end
    for (int k = 0; k < CROSS_WIN; k++) begin
      if (win_bits[(k + WIN_PER_BYTE) +: PAT_W] == pat) cross_cnt = cross_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/pattern_count_engine.sv
// Scans a message in data memory for a 5-bit pattern, counting in-byte, per-byte and
// whole-string matches, then writes the three counts back and raises done.
module pattern_count_engine
  import pce_pkg::*;
#(
  parameter int unsigned N_BYTES  = 32,
  parameter int unsigned MSG_BASE = 0,
  parameter int unsigned PAT_ADDR = 32,
  parameter int unsigned RES_ADDR = 33,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CntW = $clog2(N_BYTES + 1);
  localparam logic [AW-1:0] MsgA = AW'(MSG_BASE);
  localparam logic [AW-1:0] PatA = AW'(PAT_ADDR);
  localparam logic [AW-1:0] ResA = AW'(RES_ADDR);

  pce_state_t       state;
  logic [PAT_W-1:0] pat;
  logic [3:0]       carry;
  logic [7:0]       ctb, cto, cts;
  logic [CntW-1:0]  issue_cnt;
  logic             pat_pend;
  logic             addr_vld;
  logic             rd_vld;
  logic             first_byte;
  logic [2:0]       in_byte_cnt;
  logic [2:0]       cross_cnt;

  pce_window_match u_match (
    .win_bits    ({carry, mem_rd_data}),
    .pat         (pat),
    .in_byte_cnt (in_byte_cnt),
    .cross_cnt   (cross_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pat         <= '0;
      carry       <= 4'd0;
      ctb         <= 8'd0;
      cto         <= 8'd0;
      cts         <= 8'd0;
      issue_cnt   <= '0;
      pat_pend    <= 1'b0;
      addr_vld    <= 1'b0;
      rd_vld      <= 1'b0;
      first_byte  <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state    <= StRdPat;
            mem_addr <= PatA;
            busy     <= 1'b1;
            done     <= 1'b0;
            ctb      <= 8'd0;
            cto      <= 8'd0;
            cts      <= 8'd0;
            carry    <= 4'd0;
          end
        end
        StRdPat: begin
          state      <= StScan;
          mem_addr   <= MsgA;
          issue_cnt  <= CntW'(1);
          addr_vld   <= 1'b1;
          pat_pend   <= 1'b1;
          rd_vld     <= 1'b0;
          first_byte <= 1'b1;
        end
        StScan: begin
          // Pattern arrives first, then one message byte per cycle behind the address.
          if (pat_pend) begin
            pat      <= mem_rd_data[7:3];
            pat_pend <= 1'b0;
          end
          rd_vld <= addr_vld;
          if (issue_cnt < CntW'(N_BYTES)) begin
            mem_addr  <= mem_addr + AW'(1);
            issue_cnt <= issue_cnt + CntW'(1);
            addr_vld  <= 1'b1;
          end else begin
            addr_vld <= 1'b0;
          end
          if (rd_vld) begin
            ctb        <= ctb + {5'd0, in_byte_cnt};
            cto        <= cto + {7'd0, |in_byte_cnt};
            cts        <= cts + {5'd0, in_byte_cnt} + (first_byte ? 8'd0 : {5'd0, cross_cnt});
            carry      <= mem_rd_data[3:0];
            first_byte <= 1'b0;
          end
          if (!pat_pend && !addr_vld && !rd_vld) begin
            state       <= StWrCtb;
            mem_addr    <= ResA;
            mem_wr_en   <= 1'b1;
            mem_wr_data <= ctb;
          end
        end
        StWrCtb: begin
          state       <= StWrCto;
          mem_addr    <= ResA + AW'(1);
          mem_wr_en   <= 1'b1;
          mem_wr_data <= cto;
        end
        StWrCto: begin
          state       <= StWrCts;
          mem_addr    <= ResA + AW'(2);
          mem_wr_en   <= 1'b1;
          mem_wr_data <= cts;
        end
        StWrCts: begin
          state <= StDone;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Randomized self-checking bench for pattern_count_engine against a bit-string model.
module tb_pattern_count_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errs   = 0;

  logic [7:0] mem    [256];
  logic [7:0] wr_mem [256];
  int         wr_cnt = 0;

  logic [7:0] msg_q [32];
  logic [4:0] pat_q;
  int         exp_ctb, exp_cto, exp_cts;

  always #5 clk = ~clk;

  pattern_count_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done)
  );

  // Reads come from the stimulus image; engine writes are captured separately.
  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) begin
      wr_mem[mem_addr] <= mem_wr_data;
      wr_cnt           <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Treat the message as a 256-bit MSB-first string and slide a 5-bit window over it.
  function automatic void ref_counts();
    bit s [256];
    bit hit;
    int v;
    int p;
    exp_ctb = 0;
    exp_cto = 0;
    exp_cts = 0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 8; j++) s[8*i+j] = msg_q[i][7-j];
    for (int i = 0; i < 32; i++) begin
      hit = 1'b0;
      for (int o = 0; o < 8; o++) begin
        p = 8 * i + o;
        if (p + 4 <= 255) begin
          v = 0;
          for (int q = 0; q < 5; q++) v = (v << 1) | int'(s[p+q]);
          if (v == int'(pat_q)) begin
            exp_cts++;
            if (o < 4) begin
              exp_ctb++;
              hit = 1'b1;
            end
          end
        end
      end
      if (hit) exp_cto++;
    end
  endfunction

  task automatic load();
    logic [2:0] junk;
    junk = 3'($urandom);
    for (int i = 0; i < 32; i++) mem[i] = msg_q[i];
    mem[32] = {pat_q, junk};
    ref_counts();
  endtask

  task automatic fill_const(input logic [7:0] b, input logic [4:0] p);
    for (int i = 0; i < 32; i++) msg_q[i] = b;
    pat_q = p;
  endtask

  task automatic fill_random();
    logic [7:0] pool [4];
    int mode;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < 4; k++) pool[k] = 8'($urandom);
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       msg_q[i] = 8'($urandom);
        1:       msg_q[i] = pool[$urandom_range(0, 3)];
        default: msg_q[i] = pool[0];
      endcase
    end
    pat_q = 5'($urandom);
  endtask

  // One full run: start (optionally held), optional stray start pulses and a pattern poke.
  task automatic run_scan(input string tag, input int hold, input int ign_a, input int ign_b,
                          input int poke);
    int cyc;
    int w0;
    bit bad;
    w0    = wr_cnt;
    bad   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " accept"}, {30'd0, busy, done}, 32'd2);
    start = (hold > 0);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (!busy) bad = 1'b1;
      start = (cyc < hold) || (cyc == ign_a) || (cyc == ign_b);
      if (cyc == poke) mem[32] = 8'($urandom);
    end
    start = 1'b0;
    check({tag, " latency"}, cyc, 32'd38);
    check({tag, " busy_during_scan"}, {31'd0, bad}, 32'd0);
    check({tag, " writes"}, wr_cnt - w0, 32'd3);
    check({tag, " ctb"}, {24'd0, wr_mem[33]}, exp_ctb);
    check({tag, " cto"}, {24'd0, wr_mem[34]}, exp_cto);
    check({tag, " cts"}, {24'd0, wr_mem[35]}, exp_cts);
  endtask

  initial begin
    int w0;
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    #1;
    check("rst mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst mem_wr_data", {24'd0, mem_wr_data}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    fill_const(8'h00, 5'b00000);
    load();
    check("zeros model_cts", exp_cts, 32'd252);
    run_scan("zeros", 0, -1, -1, -1);

    fill_const(8'h55, 5'b10101);
    load();
    check("x55 model_cts", exp_cts, 32'd126);
    run_scan("x55", 0, -1, -1, -1);

    fill_const(8'hF0, 5'b11111);
    load();
    run_scan("xF0", 0, -1, -1, -1);

    // Abort mid-scan; nothing may be written and outputs return to reset values.
    fill_random();
    load();
    w0    = wr_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst mem_addr", {24'd0, mem_addr}, 32'd0);
    check("midrst mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("midrst mem_wr_data", {24'd0, mem_wr_data}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("midrst no_writes", wr_cnt - w0, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_scan("after_rst", 0, -1, -1, -1);

    // Stray starts while busy, then a held restart from DONE.
    fill_random();
    load();
    run_scan("stray_start", 0, 5, 20, -1);
    check("stray done_level", {31'd0, done}, 32'd1);
    run_scan("restart", 3, -1, -1, -1);
    w0 = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("restart single_run", wr_cnt - w0, 32'd0);
    check("restart done_held", {31'd0, done}, 32'd1);

    for (int r = 0; r < 200; r++) begin
      fill_random();
      load();
      run_scan($sformatf("rand%0d", r), 0, -1, -1, 10);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
